// File: rtl/eth_frame_arbiter_pkg.sv
// Shared types and helpers for the Ethernet frame arbiter: FIFO word layout,
// arbiter FSM states and the one-hot to index conversion used for the rr pointer.
package eth_frame_arbiter_pkg;

  localparam int ETH_DATA_W = 64;
  localparam int SOP_BIT    = 64;
  localparam int EOP_BIT    = 65;
  localparam int PTR_W      = 3;

  typedef struct packed {
    logic                  eop;
    logic                  sop;
    logic [ETH_DATA_W-1:0] data;
  } eth_word_t;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DROP
  } arb_state_t;

  function automatic logic [PTR_W-1:0] onehot2idx(input logic [7:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/eth_frame_arbiter_if.sv
// Bundle of ingress FIFO request signals and the egress word port of the arbiter.
// master is the arbiter side; slave is the FIFO/downstream side.
interface eth_frame_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 64
);

  logic [NUM_PORTS-1:0]            reqEmpty;
  logic [NUM_PORTS*(DATA_W+2)-1:0] reqData;
  logic [NUM_PORTS-1:0]            reqRdEn;
  logic [DATA_W-1:0]               outData;
  logic                            outSop;
  logic                            outEop;
  logic                            outvld;
  logic                            outReady;
  logic [NUM_PORTS-1:0]            grant;
  logic                            errNoSop;
  logic                            errOversize;

  modport master (
    input  reqEmpty, reqData, outReady,
    output reqRdEn, outData, outSop, outEop, outvld, grant, errNoSop, errOversize
  );

  modport slave (
    output reqEmpty, reqData, outReady,
    input  reqRdEn, outData, outSop, outEop, outvld, grant, errNoSop, errOversize
  );

endinterface

// File: rtl/eth_frame_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after i_ptr (wrapping), one-hot.
// The pointer register itself is owned by the parent FSM.
module eth_frame_arbiter_rr_arbiter
  import eth_frame_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  logic w_found;

  // i walks priority order (ptr+1 first); j finds the port at that rank
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!w_found && i_req[j] && (j == (int'(i_ptr) + i) % N)) begin
          o_gnt[j] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eth_frame_arbiter.sv
// Frame-level round-robin arbiter: grants one ingress FIFO for a whole frame,
// forwards its words through a single output register and polices SOP/length.
module eth_frame_arbiter
  import eth_frame_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int DATA_W          = 64,
  parameter int MAX_FRAME_WORDS = 190
) (
  input  logic                clk,
  input  logic                resetN,
  eth_frame_arbiter_if.master bus
);

  localparam int              WORD_W   = DATA_W + 2;
  localparam int              CNT_W    = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_FRAME_WORDS - 1);

  arb_state_t           r_state, w_state_nxt;
  logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
  logic [NUM_PORTS-1:0] r_grant, w_grant_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]    r_outData, w_outData_nxt;
  logic                 r_outSop, w_outSop_nxt;
  logic                 r_outEop, w_outEop_nxt;
  logic                 r_outvld, w_outvld_nxt;
  logic                 r_errNoSop, w_errNoSop_nxt;
  logic                 r_errOversize, w_errOversize_nxt;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_pick;
  logic [WORD_W-1:0]    w_head;
  logic                 w_headVld;
  logic                 w_headSop;
  logic                 w_headEop;
  logic                 w_pop;

  assign w_req = ~bus.reqEmpty;

  eth_frame_arbiter_rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  always_comb begin
    w_head    = '0;
    w_headVld = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_grant[p]) begin
        w_head    = bus.reqData[p*WORD_W +: WORD_W];
        w_headVld = !bus.reqEmpty[p];
      end
    end
  end

  assign w_headSop = w_head[DATA_W];
  assign w_headEop = w_head[DATA_W+1];

  // DROP drains the tail regardless of the output register
  always_comb begin
    case (r_state)
      XFER:    w_pop = w_headVld && (!r_outvld || bus.outReady);
      DROP:    w_pop = w_headVld;
      default: w_pop = 1'b0;
    endcase
  end

  assign bus.reqRdEn = r_grant & {NUM_PORTS{w_pop}};

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_ptr_nxt         = r_ptr;
    w_cnt_nxt         = r_cnt;
    w_outData_nxt     = r_outData;
    w_outSop_nxt      = r_outSop;
    w_outEop_nxt      = r_outEop;
    w_outvld_nxt      = r_outvld && !bus.outReady;
    w_errNoSop_nxt    = 1'b0;
    w_errOversize_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_pick) begin
          w_grant_nxt = w_pick;
          w_ptr_nxt   = onehot2idx(8'(w_pick));
          w_cnt_nxt   = '0;
          w_state_nxt = XFER;
        end
      end
      XFER: begin
        if (w_pop) begin
          if (r_cnt == '0 && !w_headSop) begin
            w_errNoSop_nxt = 1'b1;
          end else begin
            w_outData_nxt = w_head[DATA_W-1:0];
            w_outSop_nxt  = w_headSop;
            w_outEop_nxt  = w_headEop;
            w_outvld_nxt  = 1'b1;
            w_cnt_nxt     = r_cnt + CNT_W'(1);
            if (w_headEop) begin
              w_state_nxt = IDLE;
              w_grant_nxt = '0;
            end else if (r_cnt == CNT_LAST) begin
              w_outEop_nxt      = 1'b1;
              w_errOversize_nxt = 1'b1;
              w_state_nxt       = DROP;
            end
          end
        end
      end
      DROP: begin
        if (w_pop && w_headEop) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= IDLE;
      r_ptr         <= PTR_W'(NUM_PORTS - 1);
      r_grant       <= '0;
      r_cnt         <= '0;
      r_outData     <= '0;
      r_outSop      <= 1'b0;
      r_outEop      <= 1'b0;
      r_outvld      <= 1'b0;
      r_errNoSop    <= 1'b0;
      r_errOversize <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_grant       <= w_grant_nxt;
      r_cnt         <= w_cnt_nxt;
      r_outData     <= w_outData_nxt;
      r_outSop      <= w_outSop_nxt;
      r_outEop      <= w_outEop_nxt;
      r_outvld      <= w_outvld_nxt;
      r_errNoSop    <= w_errNoSop_nxt;
      r_errOversize <= w_errOversize_nxt;
    end
  end

  assign bus.outData     = r_outData;
  assign bus.outSop      = r_outSop;
  assign bus.outEop      = r_outEop;
  assign bus.outvld      = r_outvld;
  assign bus.grant       = r_grant;
  assign bus.errNoSop    = r_errNoSop;
  assign bus.errOversize = r_errOversize;

endmodule

// File: tb/tb_eth_frame_arbiter.sv
// Directed bench for eth_frame_arbiter: FWFT FIFO models per port, a frame-policing
// model producing the expected egress word stream, and a per-cycle compare process.
module tb_eth_frame_arbiter;

  localparam int NP   = 2;
  localparam int DW   = 64;
  localparam int WW   = DW + 2;
  localparam int MAXW = 4;
  localparam logic [63:0] BAD_DATA = 64'hDEAD_0000_0000_00AA;

  logic clk    = 1'b0;
  logic resetN = 1'b1;

  eth_frame_arbiter_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

  eth_frame_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .MAX_FRAME_WORDS(MAXW)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int exp_nosop = 0;
  int exp_over  = 0;
  int nosop_cnt = 0;
  int over_cnt  = 0;
  int beats     = 0;
  bit seen_bad  = 1'b0;

  logic [WW-1:0] fifo [NP][$];
  logic [WW-1:0] exp_q[$];
  logic [NP-1:0] pend;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int p = 0; p < NP; p++) begin
      bus.reqEmpty[p] = (fifo[p].size() == 0);
      if (fifo[p].size() == 0) bus.reqData[p*WW +: WW] = '0;
      else                     bus.reqData[p*WW +: WW] = fifo[p][0];
    end
  endtask

  // Pops decided by reqRdEn before the edge, FIFO heads updated just after it
  task automatic tick();
    @(negedge clk);
    pend = bus.reqRdEn;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (pend[p] && fifo[p].size() > 0) void'(fifo[p].pop_front());
    end
    refresh();
  endtask

  // Queue one frame on a port and append the policed egress words to exp_q
  task automatic send(input int port, input int n, input logic [63:0] base, input bit lead_bad);
    logic [WW-1:0] words[$];
    logic [WW-1:0] w;
    bit started, dropping;
    int k;
    if (lead_bad) words.push_back({1'b0, 1'b0, BAD_DATA});
    for (int i = 0; i < n; i++) words.push_back({(i == n - 1), (i == 0), base + 64'(i)});
    started = 1'b0; dropping = 1'b0; k = 0;
    foreach (words[i]) begin
      w = words[i];
      fifo[port].push_back(w);
      if (dropping) continue;
      if (!started && !w[DW]) begin
        exp_nosop++;
        continue;
      end
      started = 1'b1;
      if (!w[DW+1] && k == MAXW - 1) begin
        exp_q.push_back({1'b1, w[DW:0]});
        exp_over++;
        dropping = 1'b1;
      end else begin
        exp_q.push_back(w);
      end
      k++;
    end
  endtask

  task automatic rst_assert();
    resetN = 1'b0;
    #1;
    chk("reset_outputs", {bus.outData, bus.outSop, bus.outEop, bus.outvld, bus.grant,
                          bus.reqRdEn, bus.errNoSop, bus.errOversize}, '0);
    for (int p = 0; p < NP; p++) fifo[p].delete();
    exp_q.delete();
    exp_nosop = 0; exp_over = 0; nosop_cnt = 0; over_cnt = 0; beats = 0; seen_bad = 1'b0;
    bus.outReady = 1'b1;
    refresh();
    tick();
    tick();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.outvld || bus.grant != '0) && n < budget) begin
      tick();
      n++;
    end
    chk(name, (n < budget), 1'b1);
  endtask

  // Per-cycle compare against the expected egress stream and protocol rules
  initial begin : compare
    bit            stall;
    logic [WW-1:0] held;
    logic [WW-1:0] e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!resetN) begin
        stall = 1'b0;
      end else begin
        chk("rden_outside_grant", bus.reqRdEn & ~bus.grant, '0);
        chk("grant_onehot0", $onehot0(bus.grant), 1'b1);
        if (stall) chk("stall_hold", {bus.outvld, bus.outEop, bus.outSop, bus.outData}, {1'b1, held});
        if (bus.outvld && bus.outData == BAD_DATA) seen_bad = 1'b1;
        if (bus.outvld && bus.outReady) begin
          beats++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_beat: got %0h, expected no word", {bus.outEop, bus.outSop, bus.outData});
          end else begin
            e = exp_q.pop_front();
            chk("beat", {bus.outEop, bus.outSop, bus.outData}, e);
          end
        end
        nosop_cnt += int'(bus.errNoSop);
        over_cnt  += int'(bus.errOversize);
        stall = bus.outvld && !bus.outReady;
        held  = {bus.outEop, bus.outSop, bus.outData};
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [10:0] pat;
    bit          rdy_pat [4];
    int          n;
    bus.outReady = 1'b1;
    refresh();
    #2;

    // 1: single 3-word frame, cycle-exact timing
    rst_assert();
    send(0, 3, 64'h1000, 1'b0);
    tick();
    resetN = 1'b1;
    tick();
    chk("t1_grant_c1", {bus.grant, bus.outvld}, {2'b01, 1'b0});
    tick();
    chk("t1_word0", {bus.outvld, bus.outSop, bus.outEop, bus.outData}, {1'b1, 1'b1, 1'b0, 64'h1000});
    tick();
    chk("t1_word1", {bus.outvld, bus.outSop, bus.outEop, bus.outData}, {1'b1, 1'b0, 1'b0, 64'h1001});
    tick();
    chk("t1_word2", {bus.outvld, bus.outSop, bus.outEop, bus.outData, bus.grant},
        {1'b1, 1'b0, 1'b1, 64'h1002, 2'b00});
    tick();
    chk("t1_idle", {bus.outvld, bus.grant}, 3'b000);
    wait_drain("t1_drain", 20);

    // 2: both ports loaded, alternating grants with one idle gap per frame
    rst_assert();
    send(0, 2, 64'h2000, 1'b0);
    send(1, 2, 64'h3000, 1'b0);
    send(0, 2, 64'h2100, 1'b0);
    send(1, 2, 64'h3100, 1'b0);
    tick();
    resetN = 1'b1;
    tick();
    pat = '0;
    for (int i = 0; i < 11; i++) begin
      tick();
      pat = {pat[9:0], bus.outvld};
    end
    chk("t2_vld_pattern", pat, 11'b110_1101_1011);
    wait_drain("t2_drain", 40);

    // 3: back-pressure in the middle of a 4-word frame
    rst_assert();
    send(0, 4, 64'h4000, 1'b0);
    tick();
    resetN = 1'b1;
    n = 0;
    while (!bus.outvld && n < 10) begin
      tick();
      n++;
    end
    chk("t3_first_word", {bus.outvld, bus.outData}, {1'b1, 64'h4000});
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      bus.outReady = rdy_pat[i];
      #1;
      if (!rdy_pat[i]) chk("t3_stalled", {bus.reqRdEn, bus.outvld, bus.outData}, {2'b00, 1'b1, 64'h4001});
      tick();
    end
    bus.outReady = 1'b1;
    wait_drain("t3_drain", 20);
    chk("t3_beats", beats, 4);

    // 4: leading non-SOP word on port1 is dropped
    rst_assert();
    send(1, 3, 64'h5000, 1'b1);
    tick();
    resetN = 1'b1;
    wait_drain("t4_drain", 20);
    chk("t4_nosop_model", nosop_cnt, exp_nosop);
    chk("t4_nosop_count", nosop_cnt, 1);
    chk("t4_bad_word_hidden", seen_bad, 1'b0);
    chk("t4_beats", beats, 3);

    // 5: 6-word frame truncated at 4 words, then a normal frame
    rst_assert();
    send(0, 6, 64'h6000, 1'b0);
    send(0, 2, 64'h6100, 1'b0);
    tick();
    resetN = 1'b1;
    wait_drain("t5_drain", 30);
    chk("t5_over_model", over_cnt, exp_over);
    chk("t5_over_count", over_cnt, 1);
    chk("t5_nosop_count", nosop_cnt, 0);
    chk("t5_beats", beats, 6);
    chk("t5_fifo_empty", fifo[0].size(), 0);

    // 6: reset mid-frame, arbitration restarts at port0
    rst_assert();
    send(0, 5, 64'h7000, 1'b0);
    tick();
    resetN = 1'b1;
    n = 0;
    while (!(bus.outvld && bus.outData == 64'h7001) && n < 20) begin
      tick();
      n++;
    end
    chk("t6_mid_frame", {bus.outvld, bus.outData}, {1'b1, 64'h7001});
    rst_assert();
    send(0, 2, 64'h7100, 1'b0);
    send(1, 2, 64'h8100, 1'b0);
    tick();
    resetN = 1'b1;
    tick();
    chk("t6_restart_port0", bus.grant, 2'b01);
    wait_drain("t6_drain", 30);
    chk("t6_beats", beats, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
